// File: rtl/change_dispenser.sv
// Coin-return controller: on a user request or an idle timeout, pays out the
// latched balance greedily (largest coin first), one coin per cycle.
module change_dispenser #(
    parameter int kNumCoins   = 3,
    parameter int kTotalBits  = 31,
    parameter int kCoinValue0 = 100,
    parameter int kCoinValue1 = 500,
    parameter int kCoinValue2 = 1000,
    parameter int kWaitTime   = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_activity,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] i_balance,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_residue
);

    localparam int CntW = (kWaitTime < 1) ? 1 : $clog2(kWaitTime + 1);
    localparam logic [CntW-1:0]       kWaitMax = CntW'(kWaitTime);
    localparam logic [kTotalBits-1:0] kMinCoin = kTotalBits'(kCoinValue0);

    typedef enum logic [1:0] {
        IDLE,
        RETURN,
        DONE
    } state_t;

    typedef struct packed {
        logic [kNumCoins-1:0]  coin;
        logic [kTotalBits-1:0] value;
    } pick_t;

    function automatic logic [kTotalBits-1:0] coin_value(input int idx);
        case (idx)
            0:       return kTotalBits'(kCoinValue0);
            1:       return kTotalBits'(kCoinValue1);
            default: return kTotalBits'(kCoinValue2);
        endcase
    endfunction

    // Denominations ascend, so the last one that fits is the largest payable coin.
    function automatic pick_t largest_coin(input logic [kTotalBits-1:0] amount);
        pick_t p;
        p.coin  = '0;
        p.value = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (amount >= coin_value(i)) begin
                p.coin  = kNumCoins'(1) << i;
                p.value = coin_value(i);
            end
        end
        return p;
    endfunction

    state_t                state;
    logic [CntW-1:0]       wait_cnt;
    logic [kTotalBits-1:0] remaining;
    pick_t                 first_pick;
    pick_t                 next_pick;

    assign first_pick = largest_coin(i_balance);
    assign next_pick  = largest_coin(remaining);

    // remaining holds the amount still owed after the coin currently on o_return_coin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            remaining     <= '0;
            o_return_coin <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_residue     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_balance >= kMinCoin &&
                        (i_trigger_return || wait_cnt == kWaitMax)) begin
                        state         <= RETURN;
                        remaining     <= i_balance - first_pick.value;
                        o_return_coin <= first_pick.coin;
                        o_busy        <= 1'b1;
                    end else if (i_activity) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != kWaitMax) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RETURN: begin
                    if (remaining >= kMinCoin) begin
                        remaining     <= remaining - next_pick.value;
                        o_return_coin <= next_pick.coin;
                    end else begin
                        state         <= DONE;
                        o_return_coin <= '0;
                        o_done        <= 1'b1;
                        o_residue     <= remaining;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    wait_cnt  <= '0;
                    remaining <= '0;
                    o_busy    <= 1'b0;
                    o_done    <= 1'b0;
                    o_residue <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: fixed transaction table, hand-written corner
// sequences, then random traffic against a queue-based payout model.
module tb_change_dispenser;

    localparam int kWaitTime = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_activity;
    logic        i_trigger_return;
    logic [30:0] i_balance;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residue;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .kNumCoins  (3),
        .kTotalBits (31),
        .kCoinValue0(100),
        .kCoinValue1(500),
        .kCoinValue2(1000),
        .kWaitTime  (kWaitTime)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_activity      (i_activity),
        .i_trigger_return(i_trigger_return),
        .i_balance       (i_balance),
        .o_return_coin   (o_return_coin),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_residue       (o_residue)
    );

    typedef struct {
        int unsigned balance;
        int          n1000;
        int          n500;
        int          n100;
        int unsigned residue;
    } txn_t;

    typedef struct packed {
        logic [2:0]  coin;
        logic        busy;
        logic        done;
        logic [30:0] res;
    } obs_t;

    txn_t tbl [10];
    obs_t exp_cur;
    obs_t pend [$];
    int   idle_cnt;

    task automatic check(input string name, input logic [2:0] coin, input logic busy,
                         input logic done, input logic [30:0] res);
        vectors++;
        if (o_return_coin !== coin || o_busy !== busy || o_done !== done || o_residue !== res) begin
            miscompares++;
            $display("FAIL %s @%0t: got coin=%b busy=%b done=%b residue=%0d, want coin=%b busy=%b done=%b residue=%0d",
                     name, $time, o_return_coin, o_busy, o_done, o_residue, coin, busy, done, res);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n          = 1'b0;
        i_activity       = 1'b0;
        i_trigger_return = 1'b0;
        i_balance        = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_txn(input txn_t t, input string name);
        int         n = t.n1000 + t.n500 + t.n100;
        logic [2:0] want;
        @(negedge clk);
        i_balance        = 31'(t.balance);
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k < t.n1000)               want = 3'b100;
            else if (k < t.n1000 + t.n500) want = 3'b010;
            else                           want = 3'b001;
            check(name, want, 1'b1, 1'b0, 31'd0);
            // Balance changes mid-return must not affect the payout.
            i_balance = 31'($urandom_range(0, 5000));
            @(negedge clk);
        end
        check(name, 3'b000, 1'b1, 1'b1, 31'(t.residue));
        i_balance = '0;
        @(negedge clk);
        check(name, 3'b000, 1'b0, 1'b0, 31'd0);
    endtask

    task automatic run_timeout(input int act_at, input string name);
        int start = (act_at > 0) ? act_at + kWaitTime + 1 : kWaitTime + 1;
        do_reset();
        i_balance = 31'd500;
        for (int c = 1; c <= start + 2; c++) begin
            i_activity = (c == act_at);
            @(negedge clk);
            if (c < start) begin
                check(name, 3'b000, 1'b0, 1'b0, 31'd0);
            end else if (c == start) begin
                check(name, 3'b010, 1'b1, 1'b0, 31'd0);
            end else if (c == start + 1) begin
                check(name, 3'b000, 1'b1, 1'b1, 31'd0);
                i_balance = '0;
            end else begin
                check(name, 3'b000, 1'b0, 1'b0, 31'd0);
            end
        end
        i_activity = 1'b0;
    endtask

    task automatic plan_return(input logic [30:0] bal);
        int unsigned rem = 32'(bal);
        int unsigned n;
        n = rem / 1000; rem = rem % 1000;
        repeat (n) pend.push_back('{3'b100, 1'b1, 1'b0, 31'd0});
        n = rem / 500;  rem = rem % 500;
        repeat (n) pend.push_back('{3'b010, 1'b1, 1'b0, 31'd0});
        n = rem / 100;  rem = rem % 100;
        repeat (n) pend.push_back('{3'b001, 1'b1, 1'b0, 31'd0});
        pend.push_back('{3'b000, 1'b1, 1'b1, 31'(rem)});
    endtask

    // Advance the model across one rising edge given the inputs in force.
    task automatic model_step(input logic act, input logic trig, input logic [30:0] bal);
        if (exp_cur.busy) begin
            if (exp_cur.done) begin
                idle_cnt = 0;
                exp_cur  = '0;
            end else begin
                exp_cur = pend.pop_front();
            end
        end else if (bal >= 31'd100 && (trig || idle_cnt == kWaitTime)) begin
            plan_return(bal);
            exp_cur = pend.pop_front();
        end else begin
            if (act)                        idle_cnt = 0;
            else if (idle_cnt < kWaitTime)  idle_cnt = idle_cnt + 1;
            exp_cur = '0;
        end
    endtask

    initial begin
        tbl[0] = '{1600, 1, 1, 1, 0};
        tbl[1] = '{3050, 3, 0, 0, 50};
        tbl[2] = '{500,  0, 1, 0, 0};
        tbl[3] = '{2700, 2, 1, 2, 0};
        tbl[4] = '{150,  0, 0, 1, 50};
        tbl[5] = '{999,  0, 1, 4, 99};
        tbl[6] = '{100,  0, 0, 1, 0};
        tbl[7] = '{2000, 2, 0, 0, 0};
        tbl[8] = '{1099, 1, 0, 0, 99};
        tbl[9] = '{4400, 4, 0, 4, 0};

        reset_n          = 1'b0;
        i_activity       = 1'b0;
        i_trigger_return = 1'b0;
        i_balance        = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 3'b000, 1'b0, 1'b0, 31'd0);
        i_balance        = 31'd1600;
        i_trigger_return = 1'b1;
        @(negedge clk);
        check("reset_holds", 3'b000, 1'b0, 1'b0, 31'd0);
        i_balance        = '0;
        i_trigger_return = 1'b0;
        reset_n          = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("table_%0d", tbl[i].balance));

        run_timeout(0, "timeout");
        run_timeout(9, "timeout_restart");

        // Balance below the smallest coin never starts a return.
        do_reset();
        i_balance        = 31'd99;
        i_trigger_return = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check("low_bal_99", 3'b000, 1'b0, 1'b0, 31'd0);
        end
        i_balance = 31'd50;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("low_bal_50", 3'b000, 1'b0, 1'b0, 31'd0);
        end
        i_trigger_return = 1'b0;
        i_balance        = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check("zero_bal_timeout", 3'b000, 1'b0, 1'b0, 31'd0);
        end

        // Reset part-way through a return aborts it.
        do_reset();
        i_balance        = 31'd2700;
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
        check("abort_coin1", 3'b100, 1'b1, 1'b0, 31'd0);
        @(negedge clk);
        check("abort_coin2", 3'b100, 1'b1, 1'b0, 31'd0);
        #2 reset_n = 1'b0;
        #1 check("abort_async", 3'b000, 1'b0, 1'b0, 31'd0);
        i_balance = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_coin", 3'b000, 1'b0, 1'b0, 31'd0);
        end

        // A held trigger yields one return once upstream clears the balance.
        do_reset();
        i_balance        = 31'd600;
        i_trigger_return = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("held_trig", 3'b010, 1'b1, 1'b0, 31'd0);
            end else if (c == 2) begin
                check("held_trig", 3'b001, 1'b1, 1'b0, 31'd0);
            end else if (c == 3) begin
                check("held_trig", 3'b000, 1'b1, 1'b1, 31'd0);
                i_balance = '0;
            end else begin
                check("held_trig", 3'b000, 1'b0, 1'b0, 31'd0);
            end
        end
        i_trigger_return = 1'b0;

        // Random traffic against the model.
        do_reset();
        exp_cur  = '0;
        pend.delete();
        idle_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("random", exp_cur.coin, exp_cur.busy, exp_cur.done, exp_cur.res);
            if (reset_n && $urandom_range(0, 299) == 0) begin
                reset_n  = 1'b0;
                exp_cur  = '0;
                pend.delete();
                idle_cnt = 0;
            end else begin
                reset_n          = 1'b1;
                i_activity       = ($urandom_range(0, 5) == 0);
                i_trigger_return = ($urandom_range(0, 9) == 0);
                if (exp_cur.done && $urandom_range(0, 1) == 0) begin
                    i_balance = exp_cur.res;
                end else if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       i_balance = '0;
                        1:       i_balance = 31'($urandom_range(0, 99));
                        2:       i_balance = 31'(100 * $urandom_range(1, 40));
                        default: i_balance = 31'($urandom_range(0, 5000));
                    endcase
                end
                model_step(i_activity, i_trigger_return, i_balance);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter kNumCoins, 3, number of coin denominations; bit i of the coin vectors is denomination i.
REQ-002 Parameter kTotalBits, 31, width of balance and amount values.
REQ-003 Parameter kCoinValue0/1/2, 100/500/1000, value of denominations 0/1/2; values strictly ascending.
REQ-004 Parameter kWaitTime, 10, idle cycles before automatic return.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_activity  input  1  pulse; a coin was inserted or an item was selected this cycle.
REQ-008 i_trigger_return  input  1  user return request, level-sampled each cycle.
REQ-009 i_balance  input  kTotalBits  current machine balance, valid every cycle.
REQ-010 o_return_coin  output  kNumCoins  one-hot coin dispensed this cycle, or all zero.
REQ-011 o_busy  output  1  return in progress; upstream holds coin and item inputs off while high.
REQ-012 o_done  output  1  one-cycle pulse; return finished; upstream clears balance to o_residue.
REQ-013 o_residue  output  kTotalBits  amount not payable in coins, valid while o_done is high.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RETURN, DONE.
REQ-015 IDLE: the wait counter SHALL clear on i_activity and otherwise increment, saturating at kWaitTime.
REQ-016 IDLE -> RETURN SHALL occur when i_balance >= kCoinValue0 and either i_trigger_return=1 or the counter equals kWaitTime.
REQ-017 On IDLE -> RETURN, i_balance SHALL be latched into an internal remaining register; later i_balance changes are ignored until IDLE.
REQ-018 IDLE with i_balance < kCoinValue0 SHALL never start a return; a trigger in that case is dropped and no output is produced.
REQ-019 RETURN: each cycle, o_return_coin SHALL assert the bit of the largest denomination <= remaining, and remaining SHALL decrease by that value on the same edge.
REQ-020 Exactly one coin SHALL be dispensed per RETURN cycle; o_return_coin SHALL never have more than one bit set.
REQ-021 RETURN -> DONE SHALL occur on the edge after which remaining < kCoinValue0.
REQ-022 The first coin SHALL appear in the cycle after the triggering cycle (latency 1); a return of N coins occupies N RETURN cycles.
REQ-023 DONE SHALL last exactly one cycle with o_done=1, o_residue=remaining, o_return_coin=0; then DONE -> IDLE.
REQ-024 o_busy SHALL be 1 in RETURN and DONE, and 0 in IDLE.
REQ-025 The wait counter SHALL be cleared on entry to IDLE from DONE.
REQ-026 i_trigger_return and i_activity SHALL be ignored in RETURN and DONE; a held trigger SHALL NOT start a second return unless i_balance >= kCoinValue0 in IDLE.
REQ-027 Simultaneous i_activity and i_trigger_return in IDLE: the trigger SHALL take priority and the return starts.
REQ-028 Arithmetic SHALL be unsigned kTotalBits; remaining never underflows because the selected coin is <= remaining.
REQ-029 o_residue SHALL be 0 outside DONE.

Reset
REQ-030 On reset_n=0, the block SHALL asynchronously enter IDLE, with wait counter=0, remaining=0, o_return_coin=0, o_busy=0, o_done=0, o_residue=0.
REQ-031 Reset asserted mid-RETURN SHALL abort the return immediately; no further coins are issued and no o_done pulse occurs.
REQ-032 After reset_n rises, the first state update SHALL be on the next rising clk edge.

Verification
REQ-033 i_balance=1600 with a trigger pulse -> coins 1000, 500, 100 on three consecutive cycles, then o_done=1 with o_residue=0, then o_busy=0.
REQ-034 i_balance=3050 with a trigger -> 1000, 1000, 1000, then o_done with o_residue=50.
REQ-035 i_balance=500, no activity -> after 10 idle cycles a return starts with coin 500 and o_done on the following cycle; an i_activity pulse at cycle 9 restarts the 10-cycle count.
REQ-036 i_balance=50 with a trigger, or i_balance=0 with a timeout -> o_busy remains 0, no coin, no o_done.
REQ-037 i_balance=2700 with a trigger, reset_n pulled low after the second coin -> all outputs are 0 at once, the FSM is IDLE, and no third coin appears.
REQ-038 A trigger held high for 20 cycles with i_balance=600 in which upstream clears i_balance to 0 at o_done -> exactly one return sequence (500, 100).
